main_mem_responder: RTL and testbench

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

---
 rtl/cache_mem_pkg.sv | 30 +++
 rtl/mem_word_array.sv | 26 ++
 rtl/main_mem_responder.sv | 160 ++++++++++++++++
 tb/tb_main_mem_responder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache-to-main-memory responder: FSM state set,
// burst geometry helpers and the captured request record.
package cache_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_READ_WAIT   = 3'd1,
      ST_READ_BURST  = 3'd2,
      ST_WRITE_BURST = 3'd3,
      ST_WRITE_ACK   = 3'd4
   } mem_state_e;

   // Widest byte address the request record can carry; narrower buses zero-extend.
   localparam int ADDR_MAX_W = 64;

   typedef struct packed {
      logic                  write;
      logic [ADDR_MAX_W-1:0] addr;
   } mem_req_t;

   function automatic int beats_f(input int block_size, input int data_width);
      return (block_size * 8) / data_width;
   endfunction

   // Byte-within-beat offset bits, dropped when forming a word index.
   function automatic int word_off_w(input int data_width);
      return (data_width > 8) ? $clog2(data_width / 8) : 0;
   endfunction

endpackage

// File: rtl/mem_word_array.sv
// Backing store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module mem_word_array #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 1024,
   parameter int IDX_W      = $clog2(MEM_WORDS)
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [IDX_W-1:0]      i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [IDX_W-1:0]      i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/main_mem_responder.sv
// Main-memory model answering cache block refills (fixed-latency burst read)
// and writebacks (burst write, one-cycle done pulse), one transaction at a time.
module main_mem_responder
   import cache_mem_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int BLOCK_SIZE    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int MEM_WORDS     = 1024,
   parameter int READ_LATENCY  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [ADDRESS_WIDTH-1:0] req_addr,
   input  logic                     wdata_valid,
   output logic                     wdata_ready,
   input  logic [DATA_WIDTH-1:0]    wdata,
   output logic                     rdata_valid,
   input  logic                     rdata_ready,
   output logic [DATA_WIDTH-1:0]    rdata,
   output logic                     rdata_last,
   output logic                     wr_done,
   output logic                     busy
);

   localparam int BEATS  = beats_f(BLOCK_SIZE, DATA_WIDTH);
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int OFF_W  = word_off_w(DATA_WIDTH);
   localparam int IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(READ_LATENCY - 1);

   localparam logic [2:0] S_IDLE        = 3'(ST_IDLE);
   localparam logic [2:0] S_READ_WAIT   = 3'(ST_READ_WAIT);
   localparam logic [2:0] S_READ_BURST  = 3'(ST_READ_BURST);
   localparam logic [2:0] S_WRITE_BURST = 3'(ST_WRITE_BURST);
   localparam logic [2:0] S_WRITE_ACK   = 3'(ST_WRITE_ACK);

   logic [2:0]            r_state;
   logic [BEAT_W-1:0]     r_beat;
   logic [LAT_W-1:0]      r_lat;
   mem_req_t              r_req;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_rdata_valid;
   logic                  r_rdata_last;
   logic                  r_out_en;

   logic                  w_accept;
   logic                  w_we;
   logic [IDX_W-1:0]      w_base;
   logic [IDX_W-1:0]      w_wr_idx;
   logic [IDX_W-1:0]      w_rd_idx;
   logic [DATA_WIDTH-1:0] w_mem_rdata;

   assign w_accept = req_valid && req_ready;
   assign w_we     = (r_state == S_WRITE_BURST) && r_req.write && wdata_valid;

   // Indices wrap modulo MEM_WORDS simply by truncation to IDX_W bits.
   assign w_base   = IDX_W'(r_req.addr >> OFF_W);
   assign w_wr_idx = w_base + IDX_W'(r_beat);
   // Read port looks one beat ahead while bursting so rdata can be registered.
   assign w_rd_idx = (r_state == S_READ_BURST) ? (w_base + IDX_W'(r_beat) + IDX_W'(1)) : w_base;

   mem_word_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_WORDS  (MEM_WORDS),
      .IDX_W      (IDX_W)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_wr_idx),
      .i_wdata (wdata),
      .i_raddr (w_rd_idx),
      .o_rdata (w_mem_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_beat        <= '0;
         r_lat         <= '0;
         r_req         <= '0;
         r_rdata       <= '0;
         r_rdata_valid <= 1'b0;
         r_rdata_last  <= 1'b0;
         r_out_en      <= 1'b0;
      end else begin
         r_out_en <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_req  <= '{write: req_write, addr: ADDR_MAX_W'(req_addr)};
                  r_beat <= '0;
                  if (req_write) begin
                     r_state <= S_WRITE_BURST;
                  end else begin
                     r_state <= S_READ_WAIT;
                     r_lat   <= LAT_LOAD;
                  end
               end
            end
            S_READ_WAIT: begin
               if (r_lat == '0) begin
                  r_state       <= S_READ_BURST;
                  r_rdata       <= w_mem_rdata;
                  r_rdata_valid <= 1'b1;
                  r_rdata_last  <= (LAST_BEAT == '0);
               end else begin
                  r_lat <= r_lat - LAT_W'(1);
               end
            end
            S_READ_BURST: begin
               if (rdata_ready) begin
                  if (r_rdata_last) begin
                     r_state       <= S_IDLE;
                     r_beat        <= '0;
                     r_rdata_valid <= 1'b0;
                     r_rdata_last  <= 1'b0;
                  end else begin
                     r_beat       <= r_beat + BEAT_W'(1);
                     r_rdata      <= w_mem_rdata;
                     r_rdata_last <= ((r_beat + BEAT_W'(1)) == LAST_BEAT);
                  end
               end
            end
            S_WRITE_BURST: begin
               if (wdata_valid) begin
                  if (r_beat == LAST_BEAT) begin
                     r_state <= S_WRITE_ACK;
                     r_beat  <= '0;
                  end else begin
                     r_beat <= r_beat + BEAT_W'(1);
                  end
               end
            end
            S_WRITE_ACK: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // req_ready stays low until the first edge after reset releases.
   assign req_ready   = r_out_en && (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign wdata_ready = (r_state == S_WRITE_BURST);
   assign wr_done     = (r_state == S_WRITE_ACK);
   assign rdata_valid = r_rdata_valid;
   assign rdata_last  = r_rdata_last;
   assign rdata       = r_rdata;

endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: directed vector table, multi-cycle corner
// sequences and randomized transactions against a word-array memory model.
module tb_main_mem_responder;

   localparam int DW    = 32;
   localparam int BEATS = 8;
   localparam int MEMW  = 16;
   localparam int LAT   = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [31:0]   req_addr = '0;
   logic          wdata_valid = 1'b0;
   logic          wdata_ready;
   logic [DW-1:0] wdata = '0;
   logic          rdata_valid;
   logic          rdata_ready = 1'b0;
   logic [DW-1:0] rdata;
   logic          rdata_last;
   logic          wr_done;
   logic          busy;

   main_mem_responder #(
      .DATA_WIDTH    (DW),
      .BLOCK_SIZE    (32),
      .ADDRESS_WIDTH (32),
      .MEM_WORDS     (MEMW),
      .READ_LATENCY  (LAT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .wdata_valid (wdata_valid),
      .wdata_ready (wdata_ready),
      .wdata       (wdata),
      .rdata_valid (rdata_valid),
      .rdata_ready (rdata_ready),
      .rdata       (rdata),
      .rdata_last  (rdata_last),
      .wr_done     (wr_done),
      .busy        (busy)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // scoreboard and reference model
   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] exp_mem [MEMW];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] wbuf [BEATS];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int word_of(input logic [31:0] addr, input int k);
      return int'(((longint'(addr) / (DW / 8)) + k) % MEMW);
   endfunction

   task automatic push_read_exp(input logic [31:0] addr);
      for (int k = 0; k < BEATS; k++) exp_q.push_back(exp_mem[word_of(addr, k)]);
   endtask

   // driver tasks (called and returning at a falling edge)
   task automatic apply_reset();
      reset = 1'b1;
      req_valid = 1'b0; wdata_valid = 1'b0; rdata_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req_ready", {31'b0, req_ready}, 0);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_wdata_ready", {31'b0, wdata_ready}, 0);
      check("rst_rdata_valid", {31'b0, rdata_valid}, 0);
      check("rst_rdata_last", {31'b0, rdata_last}, 0);
      check("rst_wr_done", {31'b0, wr_done}, 0);
      check("rst_rdata", rdata, 0);
      reset = 1'b0;
      #1 check("req_ready_before_first_edge", {31'b0, req_ready}, 0);
      @(negedge clk);
      check("req_ready_after_first_edge", {31'b0, req_ready}, 1);
   endtask

   task automatic send_req(input logic wr, input logic [31:0] addr);
      int waited = 0;
      req_valid = 1'b1; req_write = wr; req_addr = addr;
      while (!req_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      n_checks++;
      if (!req_ready) begin
         n_fail++;
         $display("FAIL req_accept: req_ready=0 after %0d cycles, required 1", waited);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_write = 1'b0; req_addr = $urandom;
   endtask

   task automatic write_beats(input logic [31:0] addr, input int n, input int stall_beat, input int stall_len);
      for (int k = 0; k < n; k++) begin
         if (k == stall_beat) begin
            for (int s = 0; s < stall_len; s++) begin
               wdata_valid = 1'b0; wdata = $urandom;
               check("wr_stall_wdata_ready", {31'b0, wdata_ready}, 1);
               @(negedge clk);
            end
         end
         wdata_valid = 1'b1; wdata = wbuf[k];
         check("wdata_ready", {31'b0, wdata_ready}, 1);
         check("wr_done_early", {31'b0, wr_done}, 0);
         check("wr_req_ready_low", {31'b0, req_ready}, 0);
         @(negedge clk);
         exp_mem[word_of(addr, k)] = wbuf[k];
      end
      wdata_valid = 1'b0;
      if (n == BEATS) begin
         check("wr_done_pulse", {31'b0, wr_done}, 1);
         check("ack_wdata_ready", {31'b0, wdata_ready}, 0);
         check("ack_req_ready", {31'b0, req_ready}, 0);
         @(negedge clk);
         check("wr_done_one_cycle", {31'b0, wr_done}, 0);
         check("req_ready_after_ack", {31'b0, req_ready}, 1);
      end
   endtask

   task automatic read_burst(input int stall_beat, input int stall_len,
                             input logic [DW-1:0] exp_first, input logic chk_first);
      int lat = 0;
      logic [DW-1:0] exp_d;
      rdata_ready = 1'b1;
      check("rvalid_at_accept", {31'b0, rdata_valid}, 0);
      while (!rdata_valid && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      check("read_latency", 32'(lat), LAT);
      for (int k = 0; k < BEATS; k++) begin
         if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_empty: beat %0d has no expected value", k);
            break;
         end
         exp_d = exp_q.pop_front();
         if (k == 0 && chk_first) check("first_beat_table", rdata, exp_first);
         if (k == stall_beat) begin
            for (int s = 0; s < stall_len; s++) begin
               rdata_ready = 1'b0;
               check("stall_rdata_valid", {31'b0, rdata_valid}, 1);
               check("stall_rdata", rdata, exp_d);
               check("stall_rdata_last", {31'b0, rdata_last}, (k == BEATS - 1) ? 1 : 0);
               @(negedge clk);
            end
         end
         rdata_ready = 1'b1;
         check("rdata_valid", {31'b0, rdata_valid}, 1);
         check("rdata", rdata, exp_d);
         check("rdata_last", {31'b0, rdata_last}, (k == BEATS - 1) ? 1 : 0);
         check("rd_busy", {31'b0, busy}, 1);
         check("rd_req_ready_low", {31'b0, req_ready}, 0);
         @(negedge clk);
      end
      check("rvalid_drop", {31'b0, rdata_valid}, 0);
      check("rlast_drop", {31'b0, rdata_last}, 0);
      check("req_ready_after_read", {31'b0, req_ready}, 1);
   endtask

   typedef struct {
      logic          wr;
      logic [31:0]   addr;
      logic [DW-1:0] data0;      // write: first beat value; read: required first beat
      int            stall_beat;
      int            stall_len;
   } vec_t;

   vec_t vecs [8];

   task automatic run_vec(input vec_t v);
      if (v.wr) begin
         for (int k = 0; k < BEATS; k++) wbuf[k] = v.data0 + DW'(k);
         send_req(1'b1, v.addr);
         write_beats(v.addr, BEATS, v.stall_beat, v.stall_len);
      end else begin
         push_read_exp(v.addr);
         send_req(1'b0, v.addr);
         read_burst(v.stall_beat, v.stall_len, v.data0, 1'b1);
      end
   endtask

   initial begin
      vecs[0] = '{1'b1, 32'h0000_0040, 32'hA0, -1, 0};
      vecs[1] = '{1'b1, 32'h0000_0020, 32'hB0,  3, 2};
      vecs[2] = '{1'b0, 32'h0000_0040, 32'hA0, -1, 0};
      vecs[3] = '{1'b0, 32'h0000_0040, 32'hA0,  2, 3};
      vecs[4] = '{1'b1, 32'h0000_0038, 32'hC0, -1, 0};
      vecs[5] = '{1'b0, 32'h0000_0038, 32'hC0, -1, 0};
      vecs[6] = '{1'b0, 32'h0000_0040, 32'hC2, -1, 0};
      vecs[7] = '{1'b0, 32'h0000_0020, 32'hB0,  7, 2};

      @(negedge clk);
      apply_reset();

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Request held during a read burst is served afterwards with its own address.
      push_read_exp(32'h40);
      send_req(1'b0, 32'h40);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
      read_burst(-1, 0, '0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_write = 1'b0;
      check("held_req_is_write", {31'b0, wdata_ready}, 1);
      check("held_req_busy", {31'b0, busy}, 1);
      for (int k = 0; k < BEATS; k++) wbuf[k] = 32'hD0 + DW'(k);
      write_beats(32'h20, BEATS, -1, 0);
      push_read_exp(32'h20);
      send_req(1'b0, 32'h20);
      read_burst(-1, 0, 32'hD0, 1'b1);

      // Stray beat handshakes while idle must not disturb anything.
      wdata_valid = 1'b1; wdata = 32'hDEAD_BEEF; rdata_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("idle_busy", {31'b0, busy}, 0);
         check("idle_wdata_ready", {31'b0, wdata_ready}, 0);
         check("idle_rdata_valid", {31'b0, rdata_valid}, 0);
         check("idle_wr_done", {31'b0, wr_done}, 0);
      end
      wdata_valid = 1'b0;

      // Reset arriving with write beat 4 on the bus abandons the writeback.
      for (int k = 0; k < BEATS; k++) wbuf[k] = 32'hE0 + DW'(k);
      send_req(1'b1, 32'h40);
      write_beats(32'h40, 4, -1, 0);
      wdata_valid = 1'b1; wdata = wbuf[4];
      reset = 1'b1;
      #1;
      check("midrst_wdata_ready", {31'b0, wdata_ready}, 0);
      check("midrst_busy", {31'b0, busy}, 0);
      check("midrst_req_ready", {31'b0, req_ready}, 0);
      check("midrst_wr_done", {31'b0, wr_done}, 0);
      @(negedge clk);
      check("midrst_no_wr_done", {31'b0, wr_done}, 0);
      wdata_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      check("midrst_req_ready_back", {31'b0, req_ready}, 1);
      check("midrst_no_wr_done_after", {31'b0, wr_done}, 0);
      push_read_exp(32'h40);
      send_req(1'b0, 32'h40);
      read_burst(-1, 0, 32'hE0, 1'b1);

      // Randomized traffic against the model.
      for (int t = 0; t < 24; t++) begin
         logic [31:0] a;
         int sb, sl;
         a  = {$urandom_range(0, 32'h07FF_FFFF), 5'b0};
         sb = $urandom_range(0, 9);
         sl = $urandom_range(1, 3);
         if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k < BEATS; k++) wbuf[k] = $urandom;
            send_req(1'b1, a);
            write_beats(a, BEATS, sb, sl);
         end else begin
            push_read_exp(a);
            send_req(1'b0, a);
            read_burst(sb, sl, '0, 1'b0);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
